// File: rtl/systolic_array_controller.sv
// Sequencing controller for the skewed systolic array: weight load,
// ifmap streaming, pipeline drain, output-valid tracking and completion.
//
// Ports:
//   clk, rst_n           clock; synchronous active-high reset (1 = reset)
//   start, num_vectors   run request and vector count, sampled in IDLE
//   weight_valid/ready   weight row handshake (one row per beat)
//   ifmap_valid/ready    ifmap vector handshake
//   weight_en/wen        array weight-path enable and one-hot row write
//   en, ifmap_zero       array compute enable and ifmap zero-select
//   ofmap_valid/count    result strobe and results emitted this run
//   busy, done           not-idle flag and one-cycle completion pulse
module systolic_array_controller #(
    parameter int ARRAY_HEIGHT = 4,
    parameter int ARRAY_WIDTH  = 4,
    parameter int LATENCY      = 8,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [COUNT_WIDTH-1:0]  num_vectors,
    input  logic                    weight_valid,
    output logic                    weight_ready,
    input  logic                    ifmap_valid,
    output logic                    ifmap_ready,
    output logic                    weight_en,
    output logic [ARRAY_HEIGHT-1:0] weight_wen,
    output logic                    en,
    output logic                    ifmap_zero,
    output logic                    ofmap_valid,
    output logic [COUNT_WIDTH-1:0]  ofmap_count,
    output logic                    busy,
    output logic                    done
);

    localparam int ROW_W = (ARRAY_HEIGHT > 1) ? $clog2(ARRAY_HEIGHT) : 1;
    localparam int DRN_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ARRAY_HEIGHT - 1);
    localparam logic [DRN_W-1:0] LAST_DRN = DRN_W'(LATENCY - 1);
    // A zero-column array has no result lanes to flag as valid.
    localparam logic HAS_COLS = (ARRAY_WIDTH > 0);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    state_t                 state;
    state_t                 state_nx;
    logic [ROW_W-1:0]       row;
    logic [DRN_W-1:0]       drain_cnt;
    logic [COUNT_WIDTH-1:0] num_q;
    logic [COUNT_WIDTH-1:0] in_count;
    logic [LATENCY-1:0]     vld_sr;
    logic [LATENCY-1:0]     sr_next;
    logic                   accept_w;
    logic                   accept_v;
    logic                   last_vec;

    assign last_vec = (in_count == (num_q - COUNT_WIDTH'(1)));

    // Valid bit for each accepted vector travels with the array pipeline;
    // it only moves on cycles where the array itself moves.
    if (LATENCY > 1) begin : g_sr
        assign sr_next = {vld_sr[LATENCY-2:0], accept_v};
    end else begin : g_sr1
        assign sr_next = accept_v;
    end

    always_comb begin
        state_nx     = state;
        weight_ready = 1'b0;
        ifmap_ready  = 1'b0;
        weight_en    = 1'b0;
        weight_wen   = '0;
        en           = 1'b0;
        ifmap_zero   = 1'b0;
        done         = 1'b0;
        accept_w     = 1'b0;
        accept_v     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nx = LOAD_W;
            end
            LOAD_W: begin
                weight_ready = 1'b1;
                if (weight_valid) begin
                    accept_w   = 1'b1;
                    weight_en  = 1'b1;
                    weight_wen = ARRAY_HEIGHT'(1) << row;
                    if (row == LAST_ROW)
                        state_nx = (num_q == '0) ? DRAIN : STREAM;
                end
            end
            STREAM: begin
                ifmap_ready = 1'b1;
                en          = ifmap_valid;
                accept_v    = ifmap_valid;
                if (ifmap_valid && last_vec) state_nx = DRAIN;
            end
            DRAIN: begin
                en         = 1'b1;
                ifmap_zero = 1'b1;
                if (drain_cnt == LAST_DRN) state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy        = (state != IDLE);
    assign ofmap_valid = en & vld_sr[LATENCY-1] & HAS_COLS;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state       <= IDLE;
            row         <= '0;
            drain_cnt   <= '0;
            num_q       <= '0;
            in_count    <= '0;
            vld_sr      <= '0;
            ofmap_count <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                num_q       <= num_vectors;
                row         <= '0;
                drain_cnt   <= '0;
                in_count    <= '0;
                vld_sr      <= '0;
                ofmap_count <= '0;
            end else begin
                if (accept_w)
                    row <= row + ROW_W'(1);
                if (accept_v)
                    in_count <= in_count + COUNT_WIDTH'(1);
                if (state == DRAIN)
                    drain_cnt <= drain_cnt + DRN_W'(1);
                if (en)
                    vld_sr <= sr_next;
                if (ofmap_valid)
                    ofmap_count <= ofmap_count + COUNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_systolic_array_controller.sv
// Self-checking bench for systolic_array_controller: per-cycle output
// timeline against a phase/queue model, plus matrix results of the tile.
module tb_systolic_array_controller;

    localparam int H  = 4;
    localparam int W  = 4;
    localparam int L  = 8;
    localparam int CW = 16;

    typedef int vec_t[W];

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [CW-1:0] num_vectors;
    logic          weight_valid;
    logic          weight_ready;
    logic          ifmap_valid;
    logic          ifmap_ready;
    logic          weight_en;
    logic [H-1:0]  weight_wen;
    logic          en;
    logic          ifmap_zero;
    logic          ofmap_valid;
    logic [CW-1:0] ofmap_count;
    logic          busy;
    logic          done;

    int   n_chk  = 0;
    int   n_fail = 0;
    int   exp_hold = 0;
    int   wdata[H][W];
    int   wmat[H][W];
    vec_t vdata[$];
    int   tbl[4][W] = '{'{90, 100, 110, 120}, '{202, 228, 254, 280},
                        '{314, 356, 398, 440}, '{426, 484, 542, 600}};

    always #5 clk = ~clk;

    systolic_array_controller #(
        .ARRAY_HEIGHT(H),
        .ARRAY_WIDTH (W),
        .LATENCY     (L),
        .COUNT_WIDTH (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .num_vectors (num_vectors),
        .weight_valid(weight_valid),
        .weight_ready(weight_ready),
        .ifmap_valid (ifmap_valid),
        .ifmap_ready (ifmap_ready),
        .weight_en   (weight_en),
        .weight_wen  (weight_wen),
        .en          (en),
        .ifmap_zero  (ifmap_zero),
        .ofmap_valid (ofmap_valid),
        .ofmap_count (ofmap_count),
        .busy        (busy),
        .done        (done)
    );

    function automatic logic [27:0] obs();
        return {weight_ready, ifmap_ready, weight_en, weight_wen, en,
                ifmap_zero, ofmap_valid, busy, done, ofmap_count};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_basic();
        vec_t v;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) wdata[r][c] = 4 * r + c + 1;
        vdata.delete();
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < W; c++) v[c] = 4 * k + c + 1;
            vdata.push_back(v);
        end
    endtask

    task automatic fill_random(input int n);
        vec_t v;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) wdata[r][c] = int'($urandom_range(0, 15));
        vdata.delete();
        for (int k = 0; k < n; k++) begin
            for (int c = 0; c < W; c++) v[c] = int'($urandom_range(0, 15));
            vdata.push_back(v);
        end
    endtask

    // Phase model: load H rows, stream num vectors, drain L cycles, done.
    // Each accepted vector is due L en-cycles later (queue of due ticks).
    task automatic run_tile(input int num, input int wgap_row,
                            input int wgap_len, input int igap_vec,
                            input int igap_len, input bit rnd,
                            input int abort_vec, input int busy_vec,
                            input bit use_tbl, input string name);
        int ph, rows, vecs, drain, tick, gap_w, gap_i;
        int exp_cnt, n_done, n_res, guard, limit, k;
        int due[$];
        int vq[$];
        int act_r[W];
        int exp_r[W];
        bit wv, iv, e_we, e_en, e_ov, fin, aborted, bad;
        logic [H-1:0] e_wen;
        logic [27:0] a, e;
        ph = 1; rows = 0; vecs = 0; drain = 0; tick = 0;
        gap_w = 0; gap_i = 0; exp_cnt = 0; n_done = 0; n_res = 0;
        guard = 0; fin = 0; aborted = 0;
        limit = num * 8 + 200;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) wmat[r][c] = -1;

        start = 1'b1;
        num_vectors = CW'(num);
        weight_valid = 1'b0;
        ifmap_valid = 1'b0;
        #1;
        a = obs();
        e = {12'h000, CW'(exp_hold)};
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s idle: got %h want %h", name, a, e);
        end
        step();
        start = 1'b0;

        while (!fin) begin
            guard++;
            if (guard > limit) begin
                n_fail++;
                $display("FAIL %s timeout: got no done within %0d cycles", name, limit);
                break;
            end
            wv = 0;
            iv = 0;
            start = 1'b0;
            if (ph == 1) begin
                if (rows == wgap_row && gap_w < wgap_len) gap_w++;
                else wv = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            end else if (ph == 2) begin
                if (vecs == igap_vec && gap_i < igap_len) gap_i++;
                else iv = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                if (vecs == busy_vec) begin
                    start = 1'b1;
                    num_vectors = CW'($urandom);
                end
            end
            weight_valid = wv;
            ifmap_valid = iv;
            #1;
            e_we = (ph == 1) && wv;
            e_wen = e_we ? (H'(1) << rows) : H'(0);
            e_en = ((ph == 2) && iv) || (ph == 3);
            e_ov = e_en && (due.size() > 0) && (due[0] == tick + 1);
            e = {ph == 1, ph == 2, e_we, e_wen, e_en, ph == 3, e_ov,
                 1'b1, ph == 4, CW'(exp_cnt)};
            a = obs();
            n_chk++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL %s cycle%0d: got %h want %h", name, guard, a, e);
            end

            if (weight_en)
                for (int r = 0; r < H; r++)
                    if (weight_wen[r] && rows < H)
                        for (int c = 0; c < W; c++) wmat[r][c] = wdata[rows][c];
            if (en && !ifmap_zero && vecs < vdata.size()) vq.push_back(vecs);
            if (ofmap_valid) begin
                n_chk++;
                if (vq.size() == 0 || n_res >= vdata.size()) begin
                    n_fail++;
                    $display("FAIL %s result%0d: got spurious ofmap_valid want none", name, n_res);
                end else begin
                    k = vq.pop_front();
                    bad = 0;
                    for (int c = 0; c < W; c++) begin
                        act_r[c] = 0;
                        exp_r[c] = 0;
                        for (int r = 0; r < H; r++) begin
                            act_r[c] += vdata[k][r] * wmat[r][c];
                            exp_r[c] += vdata[n_res][r] * wdata[r][c];
                        end
                        if (use_tbl && n_res < 4) exp_r[c] = tbl[n_res][c];
                        if (act_r[c] !== exp_r[c]) bad = 1;
                    end
                    if (bad) begin
                        n_fail++;
                        $display("FAIL %s result%0d: got %0d %0d %0d %0d want %0d %0d %0d %0d",
                                 name, n_res, act_r[0], act_r[1], act_r[2], act_r[3],
                                 exp_r[0], exp_r[1], exp_r[2], exp_r[3]);
                    end
                end
                n_res++;
            end
            if (done) n_done++;

            if (e_en) begin
                tick++;
                if (e_ov) begin
                    void'(due.pop_front());
                    exp_cnt++;
                end
            end
            case (ph)
                1: if (wv) begin
                    rows++;
                    if (rows == H) ph = (num == 0) ? 3 : 2;
                end
                2: if (iv) begin
                    vecs++;
                    due.push_back(tick + L);
                    if (vecs == abort_vec) aborted = 1;
                    else if (vecs == num) ph = 3;
                end
                3: begin
                    drain++;
                    if (drain == L) ph = 4;
                end
                default: fin = 1;
            endcase
            if (aborted) break;
            step();
        end

        if (aborted) begin
            step();
            rst_n = 1'b1;
            weight_valid = 1'b0;
            ifmap_valid = 1'b0;
            start = 1'b0;
            step();
            rst_n = 1'b0;
            #1;
            a = obs();
            n_chk++;
            if (a !== 28'h0) begin
                n_fail++;
                $display("FAIL %s abort: got %h want %h", name, a, 28'h0);
            end
            n_chk++;
            if (n_done !== 0) begin
                n_fail++;
                $display("FAIL %s abort_done: got %0d want 0", name, n_done);
            end
            exp_hold = 0;
            return;
        end

        #1;
        a = obs();
        e = {12'h000, CW'(num)};
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s end: got %h want %h", name, a, e);
        end
        n_chk++;
        if (n_done !== 1) begin
            n_fail++;
            $display("FAIL %s done_count: got %0d want 1", name, n_done);
        end
        n_chk++;
        if (n_res !== num) begin
            n_fail++;
            $display("FAIL %s results: got %0d want %0d", name, n_res, num);
        end
        exp_hold = num;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        start = 1'b1;
        num_vectors = CW'($urandom);
        weight_valid = 1'b1;
        ifmap_valid = 1'b1;
        step();
        step();
        rst_n = 1'b0;
        start = 1'b0;
        weight_valid = 1'b1;
        ifmap_valid = 1'b1;
        #1;
        n_chk++;
        if (obs() !== 28'h0) begin
            n_fail++;
            $display("FAIL reset: got %h want %h", obs(), 28'h0);
        end
        step();
        weight_valid = 1'b0;
        ifmap_valid = 1'b0;
        #1;
        n_chk++;
        if (obs() !== 28'h0) begin
            n_fail++;
            $display("FAIL reset_idle: got %h want %h", obs(), 28'h0);
        end
        exp_hold = 0;
    endtask

    task automatic test_basic();
        fill_basic();
        run_tile(4, -1, 0, -1, 0, 0, -1, -1, 1, "basic");
    endtask

    task automatic test_weight_stalls();
        fill_basic();
        run_tile(4, 2, 2, -1, 0, 0, -1, -1, 1, "wstall");
    endtask

    task automatic test_ifmap_stalls();
        fill_basic();
        run_tile(4, -1, 0, 2, 3, 0, -1, -1, 1, "istall");
    endtask

    task automatic test_zero_vectors();
        fill_basic();
        vdata.delete();
        run_tile(0, -1, 0, -1, 0, 0, -1, -1, 0, "zero");
    endtask

    task automatic test_reset_mid_stream();
        fill_basic();
        run_tile(4, -1, 0, -1, 0, 0, 2, -1, 1, "abort");
        run_tile(4, -1, 0, -1, 0, 0, -1, -1, 1, "after_abort");
    endtask

    task automatic test_start_while_busy();
        fill_basic();
        run_tile(4, -1, 0, -1, 0, 0, -1, 1, 1, "busy_start");
        num_vectors = '0;
    endtask

    task automatic test_random();
        int n;
        for (int i = 0; i < 6; i++) begin
            n = int'($urandom_range(1, 12));
            fill_random(n);
            run_tile(n, int'($urandom_range(0, H)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, n)), int'($urandom_range(0, 4)),
                     1, -1, -1, 0, "random");
        end
    endtask

    task automatic test_max_count();
        int n;
        n = (1 << CW) - 1;
        fill_random(n);
        run_tile(n, -1, 0, -1, 0, 0, -1, -1, 0, "max");
    endtask

    initial begin
        rst_n = 1'b1;
        start = 1'b0;
        num_vectors = '0;
        weight_valid = 1'b0;
        ifmap_valid = 1'b0;
        test_reset();
        test_basic();
        test_weight_stalls();
        test_ifmap_stalls();
        test_zero_vectors();
        test_reset_mid_stream();
        test_start_while_busy();
        test_random();
        test_max_count();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
